// File: rtl/invaders_ram_arbiter.sv
// Arbitrates the shared 8 KB work/video RAM between scan-out byte fetches and the 8080.
// Video wins by default; a streak counter forces a CPU slot after MAX_VID_STREAK video grants.
module invaders_ram_arbiter #(
   parameter int MAX_VID_STREAK = 2,
   parameter int ADDR_W         = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [7:0]        vid_data,
   output logic              vid_overrun,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_ack,
   output logic              cpu_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_dout
);

   localparam int         TAG_DEPTH  = 2;
   localparam logic [2:0] STREAK_MAX = 3'(MAX_VID_STREAK);
   localparam logic       OWN_VID    = 1'b0;
   localparam logic       OWN_CPU    = 1'b1;

   logic              vid_pend_q, vid_pend_d;
   logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
   logic              vid_overrun_q, vid_overrun_d;
   logic [7:0]        vid_data_q, vid_data_d;

   logic              cpu_pend_q, cpu_pend_d;
   logic              cpu_busy_q, cpu_busy_d;
   logic              cpu_ack_prev_q, cpu_ack_prev_d;
   logic              cpu_we_q, cpu_we_d;
   logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
   logic [7:0]        cpu_din_q, cpu_din_d;
   logic [7:0]        cpu_dout_q, cpu_dout_d;
   logic              wr_ack_q, wr_ack_d;

   logic [2:0]        streak_q, streak_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic [TAG_DEPTH-1:0] tag_valid_q, tag_valid_d;
   logic [TAG_DEPTH-1:0] tag_own_q, tag_own_d;

   logic vid_grant;
   logic cpu_grant;
   logic rd_issue;
   logic rd_issue_own;
   logic cpu_capture;

   // Grant and memory-port drive, all from registered state.
   always_comb begin
      vid_grant    = vid_pend_q & ~(cpu_pend_q & (streak_q == STREAK_MAX));
      cpu_grant    = ~vid_grant & cpu_pend_q;
      rd_issue     = vid_grant | (cpu_grant & ~cpu_we_q);
      rd_issue_own = cpu_grant ? OWN_CPU : OWN_VID;

      mem_addr = mem_addr_q;
      if (vid_grant) begin
         mem_addr = vid_addr_q;
      end else if (cpu_grant) begin
         mem_addr = cpu_addr_q;
      end
      mem_we     = cpu_grant & cpu_we_q;
      mem_din    = cpu_din_q;
      mem_addr_d = mem_addr;
   end

   // Slot 0 is filled by the issuing grant; later slots shift the in-flight read tags along.
   genvar gi;
   generate
      for (gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            assign tag_valid_d[gi] = rd_issue;
            assign tag_own_d[gi]   = rd_issue_own;
         end else begin : g_shift
            assign tag_valid_d[gi] = tag_valid_q[gi-1];
            assign tag_own_d[gi]   = tag_own_q[gi-1];
         end
      end
   endgenerate

   always_comb begin
      vid_pend_d    = vid_pend_q & ~vid_grant;
      vid_addr_d    = vid_addr_q;
      vid_overrun_d = vid_overrun_q;
      if (vid_req) begin
         vid_pend_d = 1'b1;
         vid_addr_d = vid_addr;
         if (vid_pend_q & ~vid_grant) begin
            vid_overrun_d = 1'b1;
         end
      end

      // The cycle right after an ack is ignored so a lingering cpu_req cannot start a repeat access.
      cpu_capture    = cpu_req & ~cpu_busy_q & ~cpu_ack_prev_q;
      cpu_pend_d     = cpu_pend_q & ~cpu_grant;
      cpu_busy_d     = cpu_busy_q & ~cpu_ack;
      cpu_ack_prev_d = cpu_ack;
      cpu_we_d       = cpu_we_q;
      cpu_addr_d     = cpu_addr_q;
      cpu_din_d      = cpu_din_q;
      if (cpu_capture) begin
         cpu_pend_d = 1'b1;
         cpu_busy_d = 1'b1;
         cpu_we_d   = cpu_we;
         cpu_addr_d = cpu_addr;
         cpu_din_d  = cpu_din;
      end

      if (vid_grant & cpu_pend_q) begin
         streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 3'd1;
      end else begin
         streak_d = 3'd0;
      end

      wr_ack_d   = cpu_grant & cpu_we_q;
      vid_data_d = vid_data_q;
      cpu_dout_d = cpu_dout_q;
      if (tag_valid_q[0] && tag_own_q[0] == OWN_VID) begin
         vid_data_d = mem_dout;
      end
      if (tag_valid_q[0] && tag_own_q[0] == OWN_CPU) begin
         cpu_dout_d = mem_dout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid_pend_q     <= 1'b0;
         vid_addr_q     <= '0;
         vid_overrun_q  <= 1'b0;
         vid_data_q     <= 8'h00;
         cpu_pend_q     <= 1'b0;
         cpu_busy_q     <= 1'b0;
         cpu_ack_prev_q <= 1'b0;
         cpu_we_q       <= 1'b0;
         cpu_addr_q     <= '0;
         cpu_din_q      <= 8'h00;
         cpu_dout_q     <= 8'h00;
         wr_ack_q       <= 1'b0;
         streak_q       <= 3'd0;
         mem_addr_q     <= '0;
         tag_valid_q    <= '0;
         tag_own_q      <= '0;
      end else begin
         vid_pend_q     <= vid_pend_d;
         vid_addr_q     <= vid_addr_d;
         vid_overrun_q  <= vid_overrun_d;
         vid_data_q     <= vid_data_d;
         cpu_pend_q     <= cpu_pend_d;
         cpu_busy_q     <= cpu_busy_d;
         cpu_ack_prev_q <= cpu_ack_prev_d;
         cpu_we_q       <= cpu_we_d;
         cpu_addr_q     <= cpu_addr_d;
         cpu_din_q      <= cpu_din_d;
         cpu_dout_q     <= cpu_dout_d;
         wr_ack_q       <= wr_ack_d;
         streak_q       <= streak_d;
         mem_addr_q     <= mem_addr_d;
         tag_valid_q    <= tag_valid_d;
         tag_own_q      <= tag_own_d;
      end
   end

   assign vid_ack     = tag_valid_q[TAG_DEPTH-1] & (tag_own_q[TAG_DEPTH-1] == OWN_VID);
   assign cpu_ack     = wr_ack_q | (tag_valid_q[TAG_DEPTH-1] & (tag_own_q[TAG_DEPTH-1] == OWN_CPU));
   assign cpu_wait    = cpu_req & ~cpu_ack;
   assign vid_data    = vid_data_q;
   assign cpu_dout    = cpu_dout_q;
   assign vid_overrun = vid_overrun_q;

endmodule

// File: tb/tb_invaders_ram_arbiter.sv
// Self-checking bench for invaders_ram_arbiter: vector table plus hand sequences,
// with acks scored against an expectation queue.
module tb_invaders_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vid_req;
   logic [12:0] vid_addr;
   logic        vid_ack;
   logic [7:0]  vid_data;
   logic        vid_overrun;
   logic        cpu_req;
   logic        cpu_we;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        cpu_ack;
   logic        cpu_wait;
   logic [12:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      bit         chk_data;
   } exp_t;

   typedef struct {
      bit          is_cpu;
      bit          we;
      logic [12:0] addr;
      logic [7:0]  din;
      logic [7:0]  exp_data;
      int          lat;
   } vec_t;

   exp_t vid_q[$];
   exp_t cpu_q[$];
   vec_t vecs[8];

   invaders_ram_arbiter #(.MAX_VID_STREAK(2), .ADDR_W(13)) dut (
      .clk(clk), .rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_data(vid_data), .vid_overrun(vid_overrun),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM with registered read.
   logic [7:0] ram [0:8191];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   // Ack scoreboard: each ack must match the head expectation in cycle and data.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         while (vid_q.size() != 0 && vid_q[0].cyc < cyc) begin
            e = vid_q.pop_front();
            checks++; errors++;
            $display("FAIL vid_ack_missing: no ack at required cycle %0d (now %0d)", e.cyc, cyc);
         end
         while (cpu_q.size() != 0 && cpu_q[0].cyc < cyc) begin
            e = cpu_q.pop_front();
            checks++; errors++;
            $display("FAIL cpu_ack_missing: no ack at required cycle %0d (now %0d)", e.cyc, cyc);
         end
         if (vid_ack) begin
            checks++;
            if (vid_q.size() == 0) begin
               errors++;
               $display("FAIL vid_ack_unexpected: ack at cycle %0d, none required", cyc);
            end else begin
               e = vid_q.pop_front();
               if (e.cyc != cyc || vid_data !== e.data) begin
                  errors++;
                  $display("FAIL vid_ack: cycle %0d data %02h, required cycle %0d data %02h",
                           cyc, vid_data, e.cyc, e.data);
               end else begin
                  $display("vid ack  cycle %0d data %02h", cyc, vid_data);
               end
            end
         end
         if (cpu_ack) begin
            checks++;
            if (cpu_q.size() == 0) begin
               errors++;
               $display("FAIL cpu_ack_unexpected: ack at cycle %0d, none required", cyc);
            end else begin
               e = cpu_q.pop_front();
               if (e.cyc != cyc || (e.chk_data && cpu_dout !== e.data)) begin
                  errors++;
                  $display("FAIL cpu_ack: cycle %0d dout %02h, required cycle %0d dout %02h",
                           cyc, cpu_dout, e.cyc, e.data);
               end else begin
                  $display("cpu ack  cycle %0d dout %02h", cyc, cpu_dout);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_vid(input int c, input logic [7:0] d);
      exp_t e;
      e.cyc = c; e.data = d; e.chk_data = 1'b1;
      vid_q.push_back(e);
   endtask

   task automatic push_cpu(input int c, input logic [7:0] d, input bit chk_data);
      exp_t e;
      e.cyc = c; e.data = d; e.chk_data = chk_data;
      cpu_q.push_back(e);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((vid_q.size() != 0 || cpu_q.size() != 0) && guard < 30) begin
         step();
         guard++;
      end
      if (guard >= 30) begin
         checks++; errors++;
         $display("FAIL idle_timeout: acks still outstanding after %0d cycles", guard);
      end
      step();
      step();
   endtask

   // One isolated transaction: drive, check the grant cycle, hold cpu_req through its ack.
   task automatic run_single(input vec_t v);
      int t0;
      int guard = 0;
      bit drop_next = 1'b0;
      step();
      t0 = cyc;
      if (v.is_cpu) begin
         cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_din = v.din;
         push_cpu(t0 + v.lat, v.exp_data, !v.we);
      end else begin
         vid_req = 1'b1; vid_addr = v.addr;
         push_vid(t0 + v.lat, v.exp_data);
      end
      step();
      vid_req = 1'b0;
      @(negedge clk);
      chk("vec_mem_addr", 32'(mem_addr), 32'(v.addr));
      chk("vec_mem_we", 32'(mem_we), 32'(v.is_cpu & v.we));
      while (guard < 20 && (vid_q.size() != 0 || cpu_q.size() != 0 || cpu_req)) begin
         step();
         if (drop_next) cpu_req = 1'b0;
         drop_next = cpu_ack;
         guard++;
      end
      if (guard >= 20) begin
         checks++; errors++;
         $display("FAIL vec_timeout: transaction at cycle %0d never completed", t0);
         cpu_req = 1'b0;
      end
   endtask

   initial begin
      int t0;
      vec_t v;

      vecs[0] = '{1'b0, 1'b0, 13'h0400, 8'h00, 8'h5A, 3};
      vecs[1] = '{1'b1, 1'b1, 13'h1FFF, 8'hC3, 8'h00, 2};
      vecs[2] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'hC3, 3};
      vecs[3] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hC3, 3};
      vecs[4] = '{1'b1, 1'b1, 13'h0000, 8'h81, 8'h00, 2};
      vecs[5] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'h81, 3};
      vecs[6] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'h3C, 3};
      vecs[7] = '{1'b1, 1'b0, 13'h0400, 8'h00, 8'h5A, 3};

      for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
      ram[13'h0400] = 8'h5A;
      ram[13'h0123] = 8'h3C;
      ram[13'h0300] = 8'h77;
      ram[13'h0010] = 8'h11;
      ram[13'h0020] = 8'h22;
      for (int i = 0; i < 4; i++) ram[13'h0500 + i] = 8'hA0 + 8'(i);

      rst_n = 1'b0;
      vid_req = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;

      // Reset state
      #3;
      chk("rst_vid_ack", 32'(vid_ack), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_vid_overrun", 32'(vid_overrun), 0);
      chk("rst_vid_data", 32'(vid_data), 0);
      chk("rst_cpu_dout", 32'(cpu_dout), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      step(); step(); step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_cpu_wait", 32'(cpu_wait), 0);

      // Isolated transactions from the table
      for (int i = 0; i < 8; i++) begin
         run_single(vecs[i]);
      end
      wait_idle();
      chk("no_overrun_yet", 32'(vid_overrun), 0);

      // Video every cycle against a held CPU read: V, V, C, then overrun
      step(); t0 = cyc;
      vid_req = 1'b1; vid_addr = 13'h0500;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0300;
      push_vid(t0 + 3, 8'hA0);
      push_cpu(t0 + 5, 8'h77, 1'b1);
      step(); vid_addr = 13'h0501; push_vid(t0 + 4, 8'hA1);
      @(negedge clk);
      chk("t3_grant1_vid", 32'(mem_addr), 32'h0500);
      chk("t3_grant1_we", 32'(mem_we), 0);
      step(); vid_addr = 13'h0502;
      @(negedge clk);
      chk("t3_grant2_vid", 32'(mem_addr), 32'h0501);
      step(); vid_addr = 13'h0503; push_vid(t0 + 6, 8'hA3);
      @(negedge clk);
      chk("t3_grant3_cpu", 32'(mem_addr), 32'h0300);
      chk("t3_grant3_we", 32'(mem_we), 0);
      step(); vid_req = 1'b0;
      @(negedge clk);
      chk("t3_grant4_vid", 32'(mem_addr), 32'h0503);
      chk("t3_overrun", 32'(vid_overrun), 1);
      step();
      step(); cpu_req = 1'b0;
      wait_idle();

      // Simultaneous video and CPU read with streak at zero
      step(); t0 = cyc;
      vid_req = 1'b1; vid_addr = 13'h0010;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0020;
      push_vid(t0 + 3, 8'h11);
      push_cpu(t0 + 4, 8'h22, 1'b1);
      @(negedge clk);
      chk("t4_wait_t0", 32'(cpu_wait), 1);
      step(); vid_req = 1'b0;
      @(negedge clk);
      chk("t4_grant_vid", 32'(mem_addr), 32'h0010);
      chk("t4_wait_t1", 32'(cpu_wait), 1);
      step();
      @(negedge clk);
      chk("t4_grant_cpu", 32'(mem_addr), 32'h0020);
      chk("t4_wait_t2", 32'(cpu_wait), 1);
      step();
      @(negedge clk);
      chk("t4_wait_t3", 32'(cpu_wait), 1);
      step();
      @(negedge clk);
      chk("t4_wait_t4", 32'(cpu_wait), 0);
      step(); cpu_req = 1'b0;
      wait_idle();

      // Reset while a CPU read is in flight
      step();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0020;
      step();
      @(negedge clk);
      chk("t5_grant", 32'(mem_addr), 32'h0020);
      step();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_mem_we", 32'(mem_we), 0);
      chk("t5_rst_cpu_ack", 32'(cpu_ack), 0);
      chk("t5_rst_vid_ack", 32'(vid_ack), 0);
      chk("t5_rst_cpu_dout", 32'(cpu_dout), 0);
      chk("t5_rst_vid_data", 32'(vid_data), 0);
      chk("t5_rst_mem_addr", 32'(mem_addr), 0);
      chk("t5_rst_overrun", 32'(vid_overrun), 0);
      cpu_req = 1'b0;
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_no_cpu_ack", 32'(cpu_ack), 0);
         chk("t5_no_vid_ack", 32'(vid_ack), 0);
         step();
      end
      v = '{1'b1, 1'b0, 13'h0020, 8'h00, 8'h22, 3};
      run_single(v);
      wait_idle();

      // cpu_req held one cycle past its ack must not repeat the write
      step(); t0 = cyc;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0600; cpu_din = 8'h5E;
      push_cpu(t0 + 2, 8'h00, 1'b0);
      step();
      @(negedge clk);
      chk("t6_we_grant", 32'(mem_we), 1);
      chk("t6_addr_grant", 32'(mem_addr), 32'h0600);
      step();
      @(negedge clk);
      chk("t6_we_ack_cycle", 32'(mem_we), 0);
      step();
      @(negedge clk);
      chk("t6_we_extra_cycle", 32'(mem_we), 0);
      step(); cpu_req = 1'b0;
      @(negedge clk);
      chk("t6_we_after_drop", 32'(mem_we), 0);
      step();
      @(negedge clk);
      chk("t6_we_late", 32'(mem_we), 0);
      wait_idle();
      v = '{1'b1, 1'b0, 13'h0600, 8'h00, 8'h5E, 3};
      run_single(v);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
